tristate_bus_arbiter: RTL

TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

---
 rtl/tristate_bus_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/tristate_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tristate_bus_arbiter
//   Round-robin arbiter for four requesters that share one tri-state bus.
//   The block drives the granted requester's data onto the bus. A one-cycle
//   turnaround (TURN) is inserted between owners so that two drivers never
//   overlap on the bus.
//
//   Optional feature: define TSA_HOLD_LIMIT_EN to force an owner off the bus
//   after MAX_HOLD consecutive owned cycles. Without it, an owner keeps the
//   bus until its own req drops.
//
// Parameters
//   W        : bus width in bits
//   MAX_HOLD : maximum owned cycles per grant (1..255, TSA_HOLD_LIMIT_EN only)
// Ports
//   clk      : clock; all state updates on the rising edge
//   rst      : asynchronous active-high reset
//   req      : per-requester request, bit i = requester i
//   wr_data  : packed drive data, slice i = wr_data[i*W +: W]
//   bus      : shared tri-state bus
//   grant    : one-hot owner grant (registered)
//   owner_id : index of the current or last owner (registered)
//   bus_oe   : high while this block drives bus (registered)
//   busy     : high in the OWN state
//   rd_data  : bus value sampled on every edge
// -----------------------------------------------------------------------------
module tristate_bus_arbiter #(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] wr_data,
  inout  wire  [W-1:0]   bus,
  output logic [3:0]     grant,
  output logic [1:0]     owner_id,
  output logic           bus_oe,
  output logic           busy,
  output logic [W-1:0]   rd_data
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be in 1..255");
  end

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_t;

  state_t       state_q, state_d;
  logic [1:0]   owner_id_q, owner_id_d;
  logic [3:0]   grant_q, grant_d;
  logic         bus_oe_q, bus_oe_d;
  logic [W-1:0] rd_data_q, rd_data_d;
  logic [W-1:0] drv_data;
  logic         hold_hit;

`ifdef TSA_HOLD_LIMIT_EN
  logic [7:0]   hold_cnt_q, hold_cnt_d;
`endif

  // Round-robin pick: search last+1, +2, +3, then last itself. The scan runs
  // from the lowest priority upward so the highest-priority hit is the final
  // assignment.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_id_q <= 2'd3;
      grant_q    <= 4'b0000;
      bus_oe_q   <= 1'b0;
      rd_data_q  <= '0;
`ifdef TSA_HOLD_LIMIT_EN
      hold_cnt_q <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      owner_id_q <= owner_id_d;
      grant_q    <= grant_d;
      bus_oe_q   <= bus_oe_d;
      rd_data_q  <= rd_data_d;
`ifdef TSA_HOLD_LIMIT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

`ifdef TSA_HOLD_LIMIT_EN
  assign hold_hit = (hold_cnt_q == 8'(MAX_HOLD));
`else
  assign hold_hit = 1'b0;
`endif

  // Next-state logic. Non-owner requests are only looked at in IDLE/TURN.
  always_comb begin
    state_d    = state_q;
    owner_id_d = owner_id_q;
    case (state_q)
      S_IDLE, S_TURN: begin
        if (|req) begin
          state_d    = S_OWN;
          owner_id_d = rr_pick(req, owner_id_q);
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_OWN: begin
        if (!req[owner_id_q] || hold_hit) state_d = S_TURN;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef TSA_HOLD_LIMIT_EN
  // Counts owned cycles starting at 1 on the cycle the grant appears.
  always_comb begin
    hold_cnt_d = 8'd0;
    if (state_d == S_OWN) begin
      hold_cnt_d = (state_q == S_OWN) ? hold_cnt_q + 8'd1 : 8'd1;
    end
  end
`endif

  // Output logic: grant and bus_oe both derive from the same next state, so
  // bus_oe is high exactly when grant is non-zero.
  always_comb begin
    grant_d   = 4'b0000;
    bus_oe_d  = 1'b0;
    rd_data_d = bus;
    if (state_d == S_OWN) begin
      grant_d[owner_id_d] = 1'b1;
      bus_oe_d            = 1'b1;
    end
  end

  always_comb begin
    drv_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (owner_id_q == 2'(i)) drv_data = wr_data[i*W +: W];
    end
  end

  // bus_oe_q clears asynchronously on reset, so the bus floats immediately.
  assign bus      = bus_oe_q ? drv_data : {W{1'bz}};
  assign grant    = grant_q;
  assign owner_id = owner_id_q;
  assign bus_oe   = bus_oe_q;
  assign busy     = (state_q == S_OWN);
  assign rd_data  = rd_data_q;

endmodule
